// File: rtl/timer_share_arbiter.sv
// Shared interval timer with a round-robin arbiter in front of it.
// One requester at a time owns the down-counter; when its interval
// expires a one-cycle done pulse carries the owner's index.
module timer_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] load_val,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic [CNT_W-1:0]       cnt,
  output logic                   done,
  output logic [ID_W-1:0]        done_id
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [ID_W-1:0]  done_id_q, done_id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  winner_q, winner_d;

  logic             found;
  logic [ID_W-1:0]  pick;
  logic [CNT_W-1:0] pickLoad;
  logic [ID_W-1:0]  ptrAfterWinner;

  // Round-robin scan: first active request starting at the pointer.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  assign pickLoad       = load_val[int'(pick)*CNT_W +: CNT_W];
  assign ptrAfterWinner = (winner_q == ID_W'(N_REQ-1)) ? '0 : winner_q + 1'b1;

  // Next-state and registered-output logic of the grant/count/done sequence.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    ptr_d     = ptr_q;
    winner_d  = winner_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          winner_d       = pick;
          grant_d        = '0;
          grant_d[pick]  = 1'b1;
          cnt_d          = pickLoad;
          busy_d         = 1'b1;
          if (pickLoad == '0) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            done_id_d = pick;
          end else begin
            state_d = S_COUNT;
          end
        end else begin
          grant_d = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      S_COUNT: begin
        if (req[winner_q]) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end
          if (cnt_q == CNT_W'(1)) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            done_id_d = winner_q;
          end
        end else begin
          state_d = S_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          ptr_d   = ptrAfterWinner;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        ptr_d   = ptrAfterWinner;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      ptr_q     <= '0;
      winner_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      ptr_q     <= ptr_d;
      winner_q  <= winner_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign cnt     = cnt_q;
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule
